// File: rtl/case7_pkg.sv
// Shared widths, bit positions and scan FSM states
// for the case7 logic block and its preimage search.
package case7_pkg;

    localparam int VEC_W = 6;
    localparam int OUT_W = 3;

    localparam int BIT_A = 5;
    localparam int BIT_B = 4;
    localparam int BIT_C = 3;
    localparam int BIT_D = 2;
    localparam int BIT_E = 1;
    localparam int BIT_F = 0;

    localparam int BIT_Y1 = 2;
    localparam int BIT_Y2 = 1;
    localparam int BIT_Y3 = 0;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        RESP
    } state_t;

endpackage

// File: rtl/case7_eval.sv
// Combinational case7 function: {a,b,c,d,e,f} -> {y1,y2,y3}.
module case7_eval
    import case7_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic [OUT_W-1:0] y
);

    logic a, b, c, d, e, f;
    logic cd;
    logic y2;

    assign a = vec[BIT_A];
    assign b = vec[BIT_B];
    assign c = vec[BIT_C];
    assign d = vec[BIT_D];
    assign e = vec[BIT_E];
    assign f = vec[BIT_F];

    assign cd = c & d;
    assign y2 = a | b | f;

    assign y[BIT_Y1] = (a | b | cd) & ((~cd & ~f) | e);
    assign y[BIT_Y2] = y2;
    assign y[BIT_Y3] = (~(e & f) & y2) | cd;

endmodule

// File: rtl/case7_preimage_search.sv
// Sequential search of the 64-vector input space for vectors
// that map onto a requested case7 output triple.
module case7_preimage_search
    import case7_pkg::*;
#(
    parameter int SCAN_START = 0,
    parameter int COUNT_W    = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [OUT_W-1:0]   req_target,
    input  logic               req_count_all,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_found,
    output logic [VEC_W-1:0]   rsp_vec,
    output logic [COUNT_W-1:0] rsp_count
);

    localparam logic [VEC_W-1:0] START = VEC_W'(SCAN_START);

    state_t state;
    state_t state_nxt;

    logic [VEC_W-1:0] index;
    logic [VEC_W-1:0] steps;
    logic [OUT_W-1:0] target;
    logic             count_all;
    logic [OUT_W-1:0] y;
    logic             match;
    logic             last;
    logic             accept;

    case7_eval u_eval (
        .vec (index),
        .y   (y)
    );

    assign match = (y == target);
    // steps, not index, ends the scan so any start covers all 64 once
    assign last  = (steps == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if ((match && !count_all) || last) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            index     <= '0;
            steps     <= '0;
            target    <= '0;
            count_all <= 1'b0;
            rsp_vec   <= '0;
            rsp_count <= '0;
        end else if (accept) begin
            index     <= START;
            steps     <= '0;
            target    <= req_target;
            count_all <= req_count_all;
            rsp_vec   <= '0;
            rsp_count <= '0;
        end else if (state == SCAN) begin
            index <= index + VEC_W'(1);
            steps <= steps + VEC_W'(1);
            if (match) begin
                if (rsp_count == '0) begin
                    rsp_vec <= index;
                end
                if (rsp_count != '1) begin
                    rsp_count <= rsp_count + COUNT_W'(1);
                end
            end
        end
    end

    assign rsp_found = (rsp_count != '0);

endmodule
